// File: rtl/shift_add_multiplier_if.sv
// Bus bundle for shift_add_multiplier: request (start + operands) and
// completion (result, overflow flag, ready pulse, busy).
//
// Handshake: ctrl_start is a single-cycle request that is taken only while
// the multiplier is idle. The operands are sampled on that same edge. A
// request while busy (or in the completion cycle) is dropped, not queued.
// Completion is a one-cycle result_ready pulse. result and overflow stay
// valid from that pulse until the next completion. A new ctrl_start may be
// presented in the same cycle that result_ready is high.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             result_ready;
    logic             busy;

    // Requester side: drives the operands and start, observes the results.
    modport master (
        output ctrl_start,
        output operand_a,
        output operand_b,
        input  result,
        input  overflow,
        input  result_ready,
        input  busy
    );

    // Multiplier side.
    modport slave (
        input  ctrl_start,
        input  operand_a,
        input  operand_b,
        output result,
        output overflow,
        output result_ready,
        output busy
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-and-add signed multiplier.
//
// Operation:
// - The operands are reduced to their magnitudes.
// - Each RUN cycle conditionally adds the shifting multiplicand into a
//   2*WIDTH-bit accumulator.
// - The sign is applied once, in DONE.
// - The output is the low WIDTH bits of the signed product, plus a flag that
//   is set when the full product does not fit in WIDTH signed bits.
//
// Optional build macro MULT_EARLY_EXIT_EN:
// - When defined, RUN ends as soon as the shifted multiplier register becomes
//   zero, so latency tracks the highest set bit of |operand_b|.
// - When undefined, latency is always WIDTH+1 edges from the start edge.
//
// The FSM state is exported on dbgState (IDLE=0, RUN=1, DONE=2).
module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    shift_add_multiplier_if.slave        bus,
    output logic [1:0]                   dbgState
);

    localparam int CNT_W  = $clog2(WIDTH) + 1;
    localparam int PROD_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t nextState;

    // Datapath registers
    logic [PROD_W-1:0] multiplicand;
    logic [WIDTH-1:0]  multiplier;
    logic [PROD_W-1:0] accumulator;
    logic [CNT_W-1:0]  counter;
    logic              signReg;

    // Output registers
    logic [WIDTH-1:0]  resultReg;
    logic              overflowReg;
    logic              readyReg;
    logic              busyReg;

    // Combinational helpers
    logic [WIDTH-1:0]  magA;
    logic [WIDTH-1:0]  magB;
    logic [PROD_W-1:0] addend;
    logic [PROD_W-1:0] accNext;
    logic [PROD_W-1:0] mcandNext;
    logic [WIDTH-1:0]  mplierNext;
    logic [CNT_W-1:0]  cntNext;
    logic              lastIter;
    logic              runDone;
    logic [PROD_W-1:0] product;
    logic [WIDTH:0]    productTop;
    logic              overflowNext;

    assign bus.result       = resultReg;
    assign bus.overflow     = overflowReg;
    assign bus.result_ready = readyReg;
    assign bus.busy         = busyReg;
    assign dbgState         = state;

    // Operand magnitudes, and one shift-add step of the datapath.
    //
    // Magnitudes:
    // - Two's-complement negation of the most negative value gives back
    //   1 followed by zeros.
    // - Read as unsigned, that pattern is exactly 2^(WIDTH-1), so no special
    //   case is needed.
    //
    // Shift-add step:
    // - Runs once per RUN cycle.
    // - mplierNext is the post-shift multiplier value; the early-exit test
    //   uses it.
    always_comb begin
        magA       = bus.operand_a[WIDTH-1] ? (~bus.operand_a + WIDTH'(1)) : bus.operand_a;
        magB       = bus.operand_b[WIDTH-1] ? (~bus.operand_b + WIDTH'(1)) : bus.operand_b;
        addend     = multiplier[0] ? multiplicand : '0;
        accNext    = accumulator + addend;
        mcandNext  = multiplicand << 1;
        mplierNext = multiplier >> 1;
        cntNext    = counter + CNT_W'(1);
        lastIter   = (counter == CNT_W'(WIDTH - 1));
    end

    // Decide whether the current RUN cycle is the last iteration.
    always_comb begin
`ifdef MULT_EARLY_EXIT_EN
        runDone = lastIter || (mplierNext == '0);
`else
        runDone = lastIter;
`endif
    end

    // Apply the sign and detect signed overflow.
    // The product fits in WIDTH signed bits only when its top WIDTH+1 bits
    // are all zeros or all ones.
    always_comb begin
        product      = signReg ? (~accumulator + PROD_W'(1)) : accumulator;
        productTop   = product[PROD_W-1:WIDTH-1];
        overflowNext = !((&productTop) || !(|productTop));
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (bus.ctrl_start) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (runDone) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    //
    // Reset:
    // - Clears everything, which discards any operation in flight.
    //
    // Ready pulse:
    // - readyReg defaults low every cycle, so it is high for exactly the one
    //   cycle after DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            multiplicand <= '0;
            multiplier   <= '0;
            accumulator  <= '0;
            counter      <= '0;
            signReg      <= 1'b0;
            resultReg    <= '0;
            overflowReg  <= 1'b0;
            readyReg     <= 1'b0;
            busyReg      <= 1'b0;
        end else begin
            readyReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ctrl_start) begin
                        multiplicand <= {{WIDTH{1'b0}}, magA};
                        multiplier   <= magB;
                        signReg      <= bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                        accumulator  <= '0;
                        counter      <= '0;
                        busyReg      <= 1'b1;
                    end
                end
                RUN: begin
                    accumulator  <= accNext;
                    multiplicand <= mcandNext;
                    multiplier   <= mplierNext;
                    counter      <= cntNext;
                end
                DONE: begin
                    resultReg   <= product[WIDTH-1:0];
                    overflowReg <= overflowNext;
                    readyReg    <= 1'b1;
                    busyReg     <= 1'b0;
                end
                default: begin
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier.
//
// - The driver pushes the expected result, overflow flag and latency when an
//   operation is started.
// - The monitor pops one entry on every result_ready pulse and compares it.
module tb_shift_add_multiplier;

    localparam int W = 32;

    logic       clock;
    logic       reset;
    logic [1:0] dbgState;

    shift_add_multiplier_if #(.WIDTH(W)) mif();

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (mif),
        .dbgState (dbgState)
    );

    // Scoreboard: {overflow, result}, start cycle, expected latency
    logic [W:0] expQ[$];
    int         startQ[$];
    int         latQ[$];

    int  checkCnt = 0;
    int  errCnt   = 0;
    int  cycleCnt = 0;
    int  readyCnt = 0;
    int  readyMark;
    logic prevReady = 1'b0;

    // Clock and cycle counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Count one comparison and report it if the observed value differs.
    task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: full 64-bit signed product.
    // Returns {overflow, low W bits}.
    function automatic logic [W:0] modelMul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint p;
        logic [63:0] pu;
        logic ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        p   = sa * sb;
        pu  = p;
        ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        return {ovf, pu[W-1:0]};
    endfunction

`ifdef MULT_EARLY_EXIT_EN
    // Expected latency when early exit is enabled: highest set bit of |b|,
    // plus 2.
    function automatic int earlyLatency(input logic [W-1:0] b);
        logic [W-1:0] mag;
        int hb;
        mag = b[W-1] ? (~b + 32'd1) : b;
        hb  = 0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) hb = i;
        end
        return hb + 2;
    endfunction
`endif

    // Drive one request and record what it must produce.
    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        mif.ctrl_start = 1'b1;
        mif.operand_a  = a;
        mif.operand_b  = b;
        @(posedge clock);
        #1;
        mif.ctrl_start = 1'b0;
        mif.operand_a  = $urandom;
        mif.operand_b  = $urandom;
        expQ.push_back(modelMul(a, b));
        startQ.push_back(cycleCnt);
`ifdef MULT_EARLY_EXIT_EN
        latQ.push_back(earlyLatency(b));
`else
        latQ.push_back(W + 1);
`endif
        checkValue("busy_after_start", mif.busy, 1);
    endtask

    // Wait, within a bounded number of cycles, for every queued operation
    // to complete.
    task automatic waitDone();
        for (int i = 0; i < 200 && expQ.size() != 0; i++) begin
            @(negedge clock);
        end
        #1;
        if (expQ.size() != 0) begin
            checkValue("done_timeout", expQ.size(), 0);
            expQ.delete();
            startQ.delete();
            latQ.delete();
        end
    endtask

    // Monitor: compare each completion against the head of the scoreboard.
    always @(negedge clock) begin
        if (mif.result_ready) begin
            readyCnt <= readyCnt + 1;
            if (prevReady) checkValue("ready_pulse_width", 1, 0);
            if (expQ.size() == 0) begin
                checkValue("spurious_ready", 1, 0);
            end else begin
                checkValue("result", mif.result, expQ[0][W-1:0]);
                checkValue("overflow", mif.overflow, expQ[0][W]);
                checkValue("latency", cycleCnt - startQ[0], latQ[0]);
                checkValue("busy_at_ready", mif.busy, 0);
                void'(expQ.pop_front());
                void'(startQ.pop_front());
                void'(latQ.pop_front());
            end
        end
        prevReady <= mif.result_ready;
    end

    initial begin
        reset          = 1'b0;
        mif.ctrl_start = 1'b0;
        mif.operand_a  = '0;
        mif.operand_b  = '0;
        repeat (3) @(negedge clock);

        // Reset state.
        checkValue("rst_result", mif.result, 0);
        checkValue("rst_overflow", mif.overflow, 0);
        checkValue("rst_ready", mif.result_ready, 0);
        checkValue("rst_busy", mif.busy, 0);
        checkValue("rst_state", dbgState, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Directed cases, including sign and overflow boundaries.
        startOp(32'd7, 32'd6);                 waitDone();
        startOp(32'hFFFFFFFB, 32'd3);          waitDone();
        startOp(32'h80000000, 32'd1);          waitDone();
        startOp(32'h80000000, 32'hFFFFFFFF);   waitDone();
        startOp(32'h00010000, 32'h00010000);   waitDone();
        startOp(32'd0, 32'hFFFFFFF7);          waitDone();
        startOp(32'h7FFFFFFF, 32'h7FFFFFFF);   waitDone();

        // Back-to-back: the second start arrives in the ready cycle.
        startOp(32'd1234, 32'hF000_0001);
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (mif.result_ready) break;
        end
        startOp(32'hFFFF_FF00, 32'h4000_0003);
        waitDone();

        // Random operands: a mix of small and full-range values.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                startOp($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000);
            end else begin
                startOp($urandom, $urandom);
            end
            waitDone();
        end

        // A start pulse in the middle of a run is ignored.
        startOp(32'd123, 32'h7000_0001);
        repeat (10) @(negedge clock);
        mif.ctrl_start = 1'b1;
        mif.operand_a  = 32'd99;
        mif.operand_b  = 32'd77;
        @(negedge clock);
        mif.ctrl_start = 1'b0;
        checkValue("busy_ignored_start", mif.busy, 1);
        readyMark = readyCnt;
        waitDone();
        repeat (40) @(negedge clock);
        checkValue("ignored_start_ready_count", readyCnt - readyMark, 1);

        // Reset in the middle of a run discards the operation.
        startOp(32'd55, 32'h7000_0005);
        repeat (15) @(negedge clock);
        reset = 1'b0;
        #1;
        checkValue("midrst_result", mif.result, 0);
        checkValue("midrst_overflow", mif.overflow, 0);
        checkValue("midrst_ready", mif.result_ready, 0);
        checkValue("midrst_busy", mif.busy, 0);
        checkValue("midrst_state", dbgState, 0);
        expQ.delete();
        startQ.delete();
        latQ.delete();
        readyMark = readyCnt;
        @(negedge clock);
        reset = 1'b1;
        repeat (40) @(negedge clock);
        checkValue("midrst_no_ready", readyCnt - readyMark, 0);

        // The next operation after the reset completes normally.
        startOp(32'hFFFFFFF9, 32'hFFFFFFFA);   waitDone();

`ifdef MULT_EARLY_EXIT_EN
        startOp(32'd100, 32'd1);               waitDone();
        startOp(32'd3, 32'h40000000);          waitDone();
        startOp(32'd5, 32'd0);                 waitDone();
`endif

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
